// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//
// Byte FIFO in front of a UART transmitter. Upstream bytes are queued in a
// DEPTH-entry buffer. A small FSM pops one byte at a time into the o_tx_data
// register, pulses o_tx_start for one cycle, and waits for i_tx_done before
// it moves to the next byte.
//
// Write handshake: a byte is accepted on any rising i_clk edge where
// i_wr_valid and o_wr_ready are both 1. o_wr_ready is !o_full and depends
// only on registered state. A pop in the same cycle does not open a slot
// for a write while the buffer is full. The upstream side must hold
// i_wr_valid and i_wr_data stable until it sees the accepting edge.
//
// Ports
//   i_clk        system clock, rising-edge active
//   i_aresetn    asynchronous active-low reset
//   i_wr_valid   upstream byte valid
//   i_wr_data    upstream byte
//   o_wr_ready   buffer can accept a byte (!o_full)
//   i_clear      synchronous flush of queued bytes (not the in-flight byte)
//   o_tx_start   one-cycle start pulse to the transmitter
//   o_tx_data    byte presented to the transmitter
//   i_tx_done    transmitter finished the current byte
//   o_count      bytes queued, excluding the in-flight byte
//   o_empty      o_count == 0
//   o_full       o_count == DEPTH
//   o_state      debug view of the FSM state (0=IDLE, 1=START, 2=WAIT_DONE)
// -----------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter int DEPTH = 16  // power of two, 2..256
) (
  input  logic                     i_clk,
  input  logic                     i_aresetn,
  input  logic                     i_wr_valid,
  input  logic [7:0]               i_wr_data,
  output logic                     o_wr_ready,
  input  logic                     i_clear,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_data,
  input  logic                     i_tx_done,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;

  // Storage is deliberately not reset.
  logic [7:0]      mem [DEPTH];

  logic            full;
  logic            empty;
  logic            wr_en;
  logic            pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = i_wr_valid && !full;

  // ---------------------------------------------------------------------------
  // FSM next state, pop decision and output data register
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // i_tx_done is ignored here; the transmitter has not started yet.
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      tx_data_d = mem[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and occupancy update. A clear wins over a write and over the
  // queue side of a pop. The FSM still loads the popped byte, so a
  // transmission that starts on the clear edge is not lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && !i_clear) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_wr_ready = !full;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_count    = count_q;
  assign o_tx_start = (state_q == START);
  assign o_tx_data  = tx_data_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffer
//
// Directed bench for uart_tx_buffer with DEPTH=4. The single-byte,
// fill/full and back-to-back drain sequences come from a table of
// {inputs, expected outputs} records. Wrap-around, clear and asynchronous
// reset use hand-written sequences.
//
// Inputs are driven 1 ns after a rising edge. Outputs are compared 1 ns
// after the edge that the inputs were applied to.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic       i_clk;
  logic       i_aresetn;
  logic       i_wr_valid;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;
  logic       i_clear;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done;
  logic [2:0] o_count;
  logic       o_empty;
  logic       o_full;
  logic [1:0] o_state;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_aresetn  (i_aresetn),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .i_clear    (i_clear),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_state    (o_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Counters and scoreboard
  // ---------------------------------------------------------------------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       tx_done;
    logic       clear;
    logic       exp_start;
    logic [7:0] exp_data;
    logic [2:0] exp_count;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [7:0] wd, input logic dn, input logic cl);
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_tx_done  = dn;
    i_clear    = cl;
  endtask

  task automatic add(input logic wv, input logic [7:0] wd, input logic dn, input logic cl,
                     input logic es, input logic [7:0] ed, input logic [2:0] ec,
                     input logic [1:0] est);
    vec_t v;
    v.wr_valid  = wv;
    v.wr_data   = wd;
    v.tx_done   = dn;
    v.clear     = cl;
    v.exp_start = es;
    v.exp_data  = ed;
    v.exp_count = ec;
    v.exp_state = est;
    vecs.push_back(v);
  endtask

  // Compares every output against an expected count/state/data. Full, empty
  // and ready follow from the expected count.
  task automatic check_all(input string tag, input logic es, input logic [7:0] ed,
                           input logic [2:0] ec, input logic [1:0] est);
    check({tag, " start"}, 32'(o_tx_start), 32'(es));
    check({tag, " data"},  32'(o_tx_data),  32'(ed));
    check({tag, " count"}, 32'(o_count),    32'(ec));
    check({tag, " state"}, 32'(o_state),    32'(est));
    check({tag, " full"},  32'(o_full),     32'(ec == 3'(DEPTH)));
    check({tag, " empty"}, 32'(o_empty),    32'(ec == 3'd0));
    check({tag, " ready"}, 32'(o_wr_ready), 32'(ec != 3'(DEPTH)));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int sent;
    int recv;
    int wait_ctr;
    int cyc;
    logic acc;
    logic [7:0] exp_b;

    i_aresetn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset values before any clock edge.
    #3;
    check_all("reset", 1'b0, 8'h00, 3'd0, S_IDLE);
    step();
    step();
    i_aresetn = 1'b1;

    // ---- Table: single byte, fill/full, back-to-back drain ----
    // wv  wd     dn   cl  | start data   cnt  state
    add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, S_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd0, S_START);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, S_WAIT);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, S_WAIT);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, S_IDLE);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, S_IDLE);  // done ignored in IDLE
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd1, S_IDLE);
    add(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 3'd1, S_START); // write + pop
    add(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'h01, 3'd2, S_WAIT);  // done ignored in START
    add(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h01, 3'd3, S_WAIT);
    add(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h01, 3'd4, S_WAIT);
    add(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 8'h01, 3'd4, S_WAIT);  // refused when full
    add(1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h02, 3'd3, S_START); // refused despite pop
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 3'd3, S_WAIT);  // done ignored in START
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3'd2, S_START);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03, 3'd2, S_WAIT);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd1, S_START);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04, 3'd1, S_WAIT);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 3'd0, S_START);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 3'd0, S_WAIT);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05, 3'd0, S_IDLE);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h05, 3'd0, S_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr_valid, vecs[i].wr_data, vecs[i].tx_done, vecs[i].clear);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_start, vecs[i].exp_data,
                vecs[i].exp_count, vecs[i].exp_state);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // ---- Wrap-around: 10 bytes with random write gaps ----
    sent = 0;
    recv = 0;
    wait_ctr = 0;
    cyc = 0;
    while ((recv < 10 || wait_ctr != 0) && cyc < 600) begin
      i_wr_valid = (sent < 10) && ($urandom_range(0, 2) != 0);
      i_wr_data  = 8'h10 + 8'(sent);
      i_tx_done  = (wait_ctr == 1);
      if (wait_ctr > 0) wait_ctr--;
      acc = i_wr_valid && o_wr_ready;
      exp_b = i_wr_data;
      step();
      cyc++;
      if (acc) begin
        exp_q.push_back(exp_b);
        sent++;
      end
      if (o_tx_start) begin
        if (exp_q.size() == 0) begin
          check("wrap unexpected start", 32'(o_tx_data), 32'hFFFF_FFFF);
        end else begin
          check($sformatf("wrap byte%0d", recv), 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
        recv++;
        wait_ctr = $urandom_range(2, 4);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("wrap cycle budget", 32'(cyc < 600), 32'd1);
    check("wrap bytes received", 32'(recv), 32'd10);
    check("wrap scoreboard empty", 32'(exp_q.size()), 32'd0);
    step();
    check_all("wrap end", 1'b0, 8'h19, 3'd0, S_IDLE);

    // ---- Clear while a byte is in flight ----
    drive(1'b1, 8'hAF, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hB0, 1'b0, 1'b0);
    step();
    check_all("clr AF start", 1'b1, 8'hAF, 3'd1, S_START);
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    step();
    check_all("clr queued", 1'b0, 8'hAF, 3'd3, S_WAIT);
    drive(1'b1, 8'hC0, 1'b0, 1'b1);
    step();
    check_all("clr edge", 1'b0, 8'hAF, 3'd0, S_WAIT);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_all("clr hold", 1'b0, 8'hAF, 3'd0, S_WAIT);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    check_all("clr done", 1'b0, 8'hAF, 3'd0, S_IDLE);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("clr no start %0d", i), 32'(o_tx_start), 32'd0);
    end
    check_all("clr after", 1'b0, 8'hAF, 3'd0, S_IDLE);

    // ---- Asynchronous reset in WAIT_DONE with three bytes queued ----
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hD2, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hD3, 1'b0, 1'b0);
    step();
    check_all("rst pre", 1'b0, 8'hD0, 3'd3, S_WAIT);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    i_aresetn = 1'b0;
    #1;
    check_all("rst async", 1'b0, 8'h00, 3'd0, S_IDLE);
    step();
    step();
    i_aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rst quiet %0d", i), 32'(o_tx_start), 32'd0);
    end
    check_all("rst after", 1'b0, 8'h00, 3'd0, S_IDLE);

    // A new write after reset goes through normally.
    drive(1'b1, 8'hE7, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_all("rst new byte", 1'b1, 8'hE7, 3'd0, S_START);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
